tm1638_responder: RTL and testbench

- Device-side model of the TM1638 LED/key controller; the other end of the three-wire STB/CLK/DIO link driven by the host-side display/key driver.
- Decodes data, address and display-control commands, stores the 16-byte display RAM, and serves the 4-byte key-scan read.
- Used as a synthesizable emulator (host driver on one FPGA pin bank, display on another) and as the bus-functional target in host-driver benches.
- Top level owns the DIO tristate; this block exposes dio_in, dio_out and dio_oe.

---
 rtl/tm1638_responder.sv | 196 +++++++++++++++++++
 tb/tb_tm1638_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// Device-side TM1638 emulator: decodes host commands on STB/CLK/DIO,
// holds the 16-byte display RAM and serves the 4-byte key-scan read.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tm1638_strobe,
  input  logic         tm1638_clk,
  input  logic         dio_in,
  output logic         dio_out,
  output logic         dio_oe,
  input  logic [7:0]   keys_in,
  output logic [127:0] ram_flat,
  output logic         display_on,
  output logic [2:0]   display_level,
  output logic         frame_done
);

  typedef enum logic [2:0] {
    IDLE, CMD, WRITE, READ, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] stb_sync_q, sclk_sync_q, dio_sync_q;
  logic stb_prev_q, sclk_prev_q;
  logic stb_s, sclk_s, dio_s;
  logic stb_rise, stb_fall, sclk_rise, sclk_fall;

  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] snap_q, snap_d;
  logic [3:0] addr_q, addr_d;
  logic fixed_q, fixed_d;
  logic wrote_q, wrote_d;
  logic [15:0][7:0] ram_q, ram_d;
  logic disp_on_q, disp_on_d;
  logic [2:0] level_q, level_d;
  logic dio_out_q, dio_out_d;
  logic dio_oe_q, dio_oe_d;
  logic frame_done_q, frame_done_d;
  logic [7:0] new_byte;
  logic [1:0] kidx;
  logic key_bit;

  // STB and sclk idle high, so their synchronizers reset high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_sync_q  <= '1;
      sclk_sync_q <= '1;
      dio_sync_q  <= '0;
      stb_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], tm1638_strobe};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], tm1638_clk};
      dio_sync_q  <= {dio_sync_q[SYNC_STAGES-2:0], dio_in};
      stb_prev_q  <= stb_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign stb_s     = stb_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign dio_s     = dio_sync_q[SYNC_STAGES-1];
  assign stb_rise  = stb_s & ~stb_prev_q;
  assign stb_fall  = ~stb_s & stb_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign new_byte  = {dio_s, shift_q[7:1]};
  assign kidx      = byte_idx_q[1:0];

  // Key byte k carries S(k+1) in bit0 and S(k+5) in bit4
  always_comb begin
    key_bit = 1'b0;
    if (byte_idx_q < 3'd4) begin
      if (bit_cnt_q == 3'd0) key_bit = snap_q[{1'b1, ~kidx}];
      if (bit_cnt_q == 3'd4) key_bit = snap_q[{1'b0, ~kidx}];
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    snap_d       = snap_q;
    addr_d       = addr_q;
    fixed_d      = fixed_q;
    wrote_d      = wrote_q;
    ram_d        = ram_q;
    disp_on_d    = disp_on_q;
    level_d      = level_q;
    dio_out_d    = dio_out_q;
    dio_oe_d     = dio_oe_q;
    frame_done_d = 1'b0;
    if (stb_rise) begin
      state_d      = IDLE;
      dio_oe_d     = 1'b0;
      frame_done_d = wrote_q;
      wrote_d      = 1'b0;
    end else if (stb_fall) begin
      state_d   = CMD;
      bit_cnt_d = 3'd0;
      wrote_d   = 1'b0;
      dio_oe_d  = 1'b0;
    end else if (!stb_s && state_q != IDLE) begin
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = new_byte;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            CMD: begin
              state_d = IGNORE;
              unique case (new_byte[7:6])
                2'b01: begin
                  if (new_byte[1:0] == 2'b00) fixed_d = new_byte[2];
                  if (new_byte[1:0] == 2'b10) begin
                    state_d    = READ;
                    snap_d     = keys_in;
                    byte_idx_d = 3'd0;
                    dio_oe_d   = 1'b1;
                    dio_out_d  = keys_in[7];
                  end
                end
                2'b11: begin
                  addr_d  = new_byte[3:0];
                  state_d = WRITE;
                end
                2'b10: begin
                  disp_on_d = new_byte[3];
                  level_d   = new_byte[2:0];
                end
                default: ;
              endcase
            end
            WRITE: begin
              ram_d[addr_q] = new_byte;
              wrote_d       = 1'b1;
              if (!fixed_q) addr_d = addr_q + 4'd1;
            end
            READ: begin
              if (byte_idx_q != 3'd4) byte_idx_d = byte_idx_q + 3'd1;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_q == READ) begin
        dio_out_d = key_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      snap_q       <= '0;
      addr_q       <= '0;
      fixed_q      <= 1'b0;
      wrote_q      <= 1'b0;
      ram_q        <= '0;
      disp_on_q    <= 1'b0;
      level_q      <= '0;
      dio_out_q    <= 1'b0;
      dio_oe_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      snap_q       <= snap_d;
      addr_q       <= addr_d;
      fixed_q      <= fixed_d;
      wrote_q      <= wrote_d;
      ram_q        <= ram_d;
      disp_on_q    <= disp_on_d;
      level_q      <= level_d;
      dio_out_q    <= dio_out_d;
      dio_oe_q     <= dio_oe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ram_flat      = ram_q;
  assign display_on    = disp_on_q;
  assign display_level = level_q;
  assign dio_out       = dio_out_q;
  assign dio_oe        = dio_oe_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: host-side bit-banging with a
// scoreboard queue of expected values popped at each check point.
`timescale 1ns/1ps
module tb_tm1638_responder;

  localparam int HALF = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tm1638_strobe = 1'b1;
  logic         tm1638_clk = 1'b1;
  logic         dio_in = 1'b0;
  logic         dio_out;
  logic         dio_oe;
  logic [7:0]   keys_in = 8'h00;
  logic [127:0] ram_flat;
  logic         display_on;
  logic [2:0]   display_level;
  logic         frame_done;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  logic [127:0] exp_q[$];
  logic [15:0][7:0] mram = '0;
  logic [7:0] rd;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .tm1638_strobe(tm1638_strobe),
    .tm1638_clk(tm1638_clk),
    .dio_in(dio_in),
    .dio_out(dio_out),
    .dio_oe(dio_oe),
    .keys_in(keys_in),
    .ram_flat(ram_flat),
    .display_on(display_on),
    .display_level(display_level),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_done === 1'b1) fd_cnt++;

  task automatic expect_val(input logic [127:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [127:0] obs);
    logic [127:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] key_byte(input logic [7:0] s, input int k);
    logic [7:0] r;
    r = 8'h00;
    if (k < 4) begin
      r[0] = s[7-k];
      r[4] = s[3-k];
    end
    return r;
  endfunction

  task automatic stb_low();
    tm1638_strobe = 1'b0;
    #HALF;
  endtask

  task automatic stb_high();
    tm1638_clk = 1'b1;
    #HALF;
    tm1638_strobe = 1'b1;
    #(2*HALF);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm1638_clk = 1'b0;
      dio_in = b[i];
      #HALF;
      tm1638_clk = 1'b1;
      #HALF;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      tm1638_clk = 1'b0;
      #HALF;
      b[i] = dio_out;
      tm1638_clk = 1'b1;
      #HALF;
    end
  endtask

  task automatic window1(input logic [7:0] b);
    stb_low();
    send_byte(b);
    stb_high();
  endtask

  initial begin
    #23;
    expect_val(128'h0); check("rst_ram", ram_flat);
    expect_val(128'h0); check("rst_disp_on", display_on);
    expect_val(128'h0); check("rst_level", display_level);
    expect_val(128'h0); check("rst_dio_out", dio_out);
    expect_val(128'h0); check("rst_dio_oe", dio_oe);
    expect_val(128'h0); check("rst_frame_done", frame_done);
    #17 rst = 1'b0;
    #100;

    // Display write: auto-increment over the whole RAM
    window1(8'h40);
    stb_low();
    send_byte(8'hC0);
    for (int n = 0; n < 16; n++) begin
      send_byte(n[7:0]);
      mram[n] = n[7:0];
    end
    stb_high();
    window1(8'h8F);
    expect_val(mram);   check("disp_ram", ram_flat);
    expect_val(128'd1); check("disp_fd_cnt", fd_cnt);
    expect_val(128'd1); check("disp_on", display_on);
    expect_val(128'd7); check("disp_level", display_level);

    // Fixed-address mode
    window1(8'h44);
    stb_low();
    send_byte(8'hC5);
    send_byte(8'hAA);
    send_byte(8'h55);
    stb_high();
    mram[5] = 8'h55;
    expect_val(mram);   check("fixed_ram", ram_flat);
    expect_val(128'd2); check("fixed_fd_cnt", fd_cnt);

    // Address wrap 15 -> 0
    window1(8'h40);
    stb_low();
    send_byte(8'hCF);
    send_byte(8'h11);
    send_byte(8'h22);
    stb_high();
    mram[15] = 8'h11;
    mram[0]  = 8'h22;
    expect_val(mram);   check("wrap_ram", ram_flat);
    expect_val(128'd3); check("wrap_fd_cnt", fd_cnt);

    // Key read, plus one byte past the four real ones
    keys_in = 8'b1000_0101;
    expect_val(128'h0); check("key_oe_before", dio_oe);
    stb_low();
    send_byte(8'h42);
    expect_val(128'h1); check("key_oe_inside", dio_oe);
    for (int k = 0; k < 5; k++) begin
      read_byte(rd);
      expect_val({120'h0, key_byte(keys_in, k)});
      check($sformatf("key_byte%0d", k), {120'h0, rd});
    end
    stb_high();
    expect_val(128'h0); check("key_oe_after", dio_oe);
    expect_val(128'd3); check("key_fd_cnt", fd_cnt);

    // Aborted byte then a normal window
    stb_low();
    send_byte(8'hC3);
    send_bits(8'hFF, 4);
    stb_high();
    expect_val(mram);   check("abort_ram", ram_flat);
    expect_val(128'd3); check("abort_fd_cnt", fd_cnt);
    stb_low();
    send_byte(8'hC3);
    send_byte(8'h77);
    stb_high();
    mram[3] = 8'h77;
    expect_val(mram);   check("after_abort_ram", ram_flat);
    expect_val(128'd4); check("after_abort_fd_cnt", fd_cnt);

    // Reset in the middle of byte 1 of a read
    keys_in = 8'hFF;
    stb_low();
    send_byte(8'h42);
    read_byte(rd);
    expect_val(128'h1); check("mid_oe_pre", dio_oe);
    for (int i = 0; i < 3; i++) begin
      tm1638_clk = 1'b0;
      #HALF;
      tm1638_clk = 1'b1;
      #HALF;
    end
    #3 rst = 1'b1;
    #1;
    expect_val(128'h0); check("mid_oe_async", dio_oe);
    mram = '0;
    expect_val(mram);   check("mid_ram", ram_flat);
    expect_val(128'h0); check("mid_disp_on", display_on);
    expect_val(128'h0); check("mid_level", display_level);
    expect_val(128'h0); check("mid_dio_out", dio_out);
    tm1638_strobe = 1'b1;
    tm1638_clk = 1'b1;
    #50 rst = 1'b0;
    #100;
    window1(8'h40);
    stb_low();
    send_byte(8'hC2);
    send_byte(8'hAB);
    send_byte(8'hCD);
    stb_high();
    mram[2] = 8'hAB;
    mram[3] = 8'hCD;
    expect_val(mram);   check("post_rst_ram", ram_flat);
    expect_val(128'd5); check("post_rst_fd_cnt", fd_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
